// File: rtl/riscv_mem_pkg.sv
// Shared memory-access encodings for the core's decode/MEM stages and the data memory.
`timescale 1ns/1ps
package riscv_mem_pkg;

    // Access size field as carried by load/store instructions
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;  // reserved, always an error

    // Data-memory controller state: sweeping to zero, or serving requests
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data memory: store strobes/replication and
// load extraction with sign/zero extension. Purely combinational.
`timescale 1ns/1ps
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Select lanes and build replicated store data; extract and extend load data
    always_comb begin
        strobe_o   = 4'b0000;
        wdata_o    = wdata_i;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        rbyte      = 8'(rword_i >> {addr_lo_i, 3'b000});
        rhalf      = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_B: begin
                strobe_o = 4'b0001 << addr_lo_i;
                wdata_o  = {4{wdata_i[7:0]}};
                rdata_o  = unsigned_i ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_H: begin
                strobe_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = unsigned_i ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
                misalign_o = addr_lo_i[0];
            end
            SZ_W: begin
                strobe_o   = 4'b1111;
                rdata_o    = rword_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with integrated load/store unit for the MEM
// stage. Contents are zeroed by a one-word-per-cycle sweep after reset.
`timescale 1ns/1ps
module dmem_lsu
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    // Extra bit on the sweep counter keeps the terminal compare from wrapping
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0] IDX_ONE  = (IDX_W+1)'(1);

    logic [31:0]      mem_q [DEPTH];
    state_e           state_q;
    logic [IDX_W:0]   clr_idx_q;
    logic             rsp_valid_q, rsp_err_q;
    logic [31:0]      rsp_rdata_q;

    logic             accept, oor, err, misalign, do_store;
    logic [IDX_W-1:0] widx;
    logic [31:0]      rword, wdata_al, rdata_ext;
    logic [3:0]       strobe;

    assign req_ready = (state_q == ST_READY);
    assign busy      = (state_q == ST_CLEAR);
    assign accept    = req_valid && req_ready;
    assign widx      = req_addr[IDX_W+1:2];
    // Any set bit above the word index means the word index is >= DEPTH
    assign oor       = |req_addr[ADDR_W-1:IDX_W+2];
    assign rword     = mem_q[widx];
    assign err       = oor || misalign || (req_size == SZ_X);
    assign do_store  = accept && req_we && !err;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    lsu_align u_align (
        .size_i     (req_size),
        .addr_lo_i  (req_addr[1:0]),
        .unsigned_i (req_unsigned),
        .wdata_i    (req_wdata),
        .rword_i    (rword),
        .strobe_o   (strobe),
        .wdata_o    (wdata_al),
        .rdata_o    (rdata_ext),
        .misalign_o (misalign)
    );

    // Controller FSM (sweep then serve) and the registered response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_idx_q <= clr_idx_q + IDX_ONE;
                    if (clr_idx_q == LAST_IDX) state_q <= ST_READY;
                end
                default: ;
            endcase
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && err;
            rsp_rdata_q <= (accept && !err && !req_we) ? rdata_ext : 32'h0;
        end
    end

    // Memory array: sweep writes during clear, strobed lane writes for stores
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_idx_q[IDX_W-1:0]] <= 32'h0;
            end else if (do_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (strobe[b]) mem_q[widx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu against a byte-array reference model.
`timescale 1ns/1ps
module tb_dmem_lsu;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    logic [7:0] rmem [4*DEPTH];

    dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // Reference: byte-addressed little-endian memory; applies stores, returns load value
    task automatic model(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd);
        int n;
        logic [31:0] v;
        e  = (sz == 2'b11) || (a >= 32'(4*DEPTH)) ||
             (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
        rd = 32'h0;
        if (!e) begin
            n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            if (we) begin
                for (int k = 0; k < n; k++) rmem[a + k] = 8'(wd >> (8*k));
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v = v | (32'(rmem[a + k]) << (8*k));
                if (!uns && n == 1 && v[7])  v = v | 32'hFFFFFF00;
                if (!uns && n == 2 && v[15]) v = v | 32'hFFFF0000;
                rd = v;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4*DEPTH; i++) rmem[i] = 8'h00;
    endtask

    // One request, response checked the cycle after acceptance
    task automatic xfer(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input string nm);
        logic e;
        logic [31:0] rd;
        model(we, a, sz, uns, wd, e, rd);
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_err !== e || rsp_rdata !== rd) begin
            errs++;
            $display("FAIL %s addr=%h: got v=%b e=%b d=%h, want v=1 e=%b d=%h",
                     nm, a, rsp_valid, rsp_err, rsp_rdata, e, rd);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 3*DEPTH) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_sweep(input string nm);
        int n;
        count_busy(n);
        vecs++;
        if (n != DEPTH || req_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s: busy cycles %0d ready=%b, want %0d ready=1", nm, n, req_ready, DEPTH);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
            busy !== 1'b1 || req_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: got v=%b e=%b d=%h busy=%b rdy=%b, want 0 0 0 1 0",
                     rsp_valid, rsp_err, rsp_rdata, busy, req_ready);
        end
        rst = 1'b1;
        check_sweep("first_sweep");
        clear_model();
        for (int i = 0; i < 16; i++)
            xfer(1'b1, 32'($urandom_range(0, DEPTH-1)) * 4, 2'b10, 1'b0, $urandom, "preload");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        check_sweep("clear_sweep");
        for (int w = 0; w < DEPTH; w++) xfer(1'b0, 32'(w*4), 2'b10, 1'b0, 32'h0, "cleared_word");
        // Interrupt a sweep at index 500 and expect a full restart
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_sweep("restart_sweep");
    endtask

    task automatic test_byte_lanes();
        xfer(1'b1, 32'h10, 2'b10, 1'b0, 32'h11223344, "st_word");
        xfer(1'b1, 32'h11, 2'b00, 1'b0, 32'h000000AA, "st_byte");
        xfer(1'b1, 32'h12, 2'b01, 1'b0, 32'h0000BEEF, "st_half");
        xfer(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "ld_word");
        vecs++;
        if (rsp_rdata !== 32'hBEEFAA44) begin
            errs++;
            $display("FAIL lanes_const: got %h, want beefaa44", rsp_rdata);
        end
    endtask

    task automatic test_extension();
        xfer(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, "ld_byte_s");
        xfer(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, "ld_byte_u");
        xfer(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, "ld_half_s");
        xfer(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, "ld_half_u");
        xfer(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, "ld_word_u");
    endtask

    task automatic test_errors();
        xfer(1'b1, 32'h13, 2'b10, 1'b0, 32'hDEADBEEF, "err_word_mis");
        xfer(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "err_unchanged_a");
        xfer(1'b0, 32'h01, 2'b01, 1'b0, 32'h0, "err_half_mis");
        xfer(1'b1, 32'h10, 2'b11, 1'b0, 32'h55555555, "err_size");
        xfer(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, "err_size_ld");
        xfer(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "err_unchanged_b");
        xfer(1'b1, 32'(4*DEPTH), 2'b10, 1'b0, 32'h77777777, "err_oor");
        xfer(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, "err_unchanged_c");
        xfer(1'b0, 32'h80000000, 2'b00, 1'b0, 32'h0, "err_oor_hi");
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] sz);
        logic [31:0] a;
        a = 32'($urandom_range(0, 4*DEPTH-1));
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic test_back_to_back();
        logic        we  [8];
        logic [31:0] ad  [8];
        logic [1:0]  sz  [8];
        logic        un  [8];
        logic [31:0] wd  [8];
        logic        e;
        logic [31:0] rd;
        for (int i = 0; i < 6; i++) begin
            we[i] = 1'($urandom); sz[i] = 2'($urandom_range(0, 2));
            ad[i] = rand_addr(sz[i]); un[i] = 1'($urandom); wd[i] = $urandom;
        end
        we[6] = 1'b1; ad[6] = 32'h20; sz[6] = 2'b10; un[6] = 1'b0; wd[6] = 32'hCAFEF00D;
        we[7] = 1'b0; ad[7] = 32'h20; sz[7] = 2'b10; un[7] = 1'b0; wd[7] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            model(we[i], ad[i], sz[i], un[i], wd[i], e, rd);
            req_valid = 1'b1; req_we = we[i]; req_addr = ad[i]; req_size = sz[i];
            req_unsigned = un[i]; req_wdata = wd[i];
            @(posedge clk); #1;
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_err !== e || rsp_rdata !== rd) begin
                errs++;
                $display("FAIL stream[%0d] addr=%h: got v=%b e=%b d=%h, want v=1 e=%b d=%h",
                         i, ad[i], rsp_valid, rsp_err, rsp_rdata, e, rd);
            end
        end
        req_valid = 1'b0;
        vecs++;
        if (rsp_rdata !== 32'hCAFEF00D) begin
            errs++;
            $display("FAIL stream_fwd: got %h, want cafef00d", rsp_rdata);
        end
        @(posedge clk); #1;
        vecs++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            errs++;
            $display("FAIL idle_rsp: got v=%b d=%h, want v=0 d=0", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : rand_addr(sz);
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 4*DEPTH-1));
            xfer(1'($urandom), a, sz, 1'($urandom), $urandom, "random");
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_reset_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_ready: got v=%b busy=%b rdy=%b, want 0 1 0", rsp_valid, busy, req_ready);
        end
        rst = 1'b1;
        clear_model();
        check_sweep("ready_sweep");
        xfer(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "post_clear_a");
        xfer(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, "post_clear_b");
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_extension();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_ready();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, byte-addressable data memory with an integrated load/store unit for the RISC-V core's MEM stage. It supports byte/half/word stores through lane strobes and sign/zero-extended loads, and flags misaligned, out-of-range and illegal-size accesses. Contents are cleared by a sequential post-reset sweep instead of a single-cycle clear. It uses a valid/ready request port and a registered one-cycle response.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4
- ADDR_W, 32, byte-address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data, right-justified (bits [7:0] for byte)
- rsp_valid  out  1  response for the request accepted on the previous edge
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal size
- busy  out  1  clear sweep in progress

## Operation
- FSM states: CLEAR, READY.
- rst=0: state←CLEAR, clr_idx←0, rsp_valid←0, rsp_rdata←0, rsp_err←0. Memory is not written while rst=0.
- CLEAR: each cycle with rst=1, mem[clr_idx]←0 and clr_idx←clr_idx+1. When the write at clr_idx=DEPTH-1 completes, state←READY. busy=1 and req_ready=0 throughout CLEAR.
- READY: req_ready=1 and busy=0 (combinational from state).
- Word index = req_addr[ADDR_W-1:2].
- Error conditions:
  - out-of-range when word index ≥ DEPTH
  - half access with addr[0]=1
  - word access with addr[1:0]≠0
  - req_size=11
- On an error, no memory write occurs, rsp_err=1, rsp_rdata=0.
- Store, byte: lane strobe = 1 << addr[1:0]; wdata[7:0] is replicated to all lanes.
- Store, half: strobe = 0011 or 1100, selected by addr[1]; wdata[15:0] is replicated to both halves.
- Store, word: strobe = 1111.
- Only lanes whose strobe is set are modified.
- Load: the selected byte or half is shifted down to bit 0, then zero- or sign-extended to 32 bits. Word loads ignore req_unsigned.
- Store response: rsp_valid=1, rsp_rdata=0, rsp_err as computed.
- Cycles with no accepted request: rsp_valid←0, rsp_err←0, rsp_rdata←0.

## Timing
- Accept edge T: the store write and the load read of the word both take place at edge T.
- Response is registered; rsp_* is valid in the cycle after T. Latency is 1 and throughput is 1 request/cycle.
- Back-to-back store then load to the same word: the load accepted at T+1 returns the data stored at T.
- A load and a store in the same cycle are impossible (single port).
- Reset mid-CLEAR restarts the sweep at index 0.
- Reset in READY re-enters CLEAR; the in-flight response is dropped (rsp_valid←0).
- First possible accept is DEPTH cycles after the first cycle with rst=1.
- clr_idx is $clog2(DEPTH)+1 bits wide, so the terminal compare does not wrap.

## Structure
- Shared package riscv_mem_pkg holds:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - FSM state enum {ST_CLEAR, ST_READY}
- The same package is also used by the core's decode and MEM stages.
- Sub-module lsu_align: combinational. Takes size, addr[1:0], unsigned, wdata and the read word. Produces strobe[3:0], aligned wdata, extended rdata and the misalign flag.
- The memory array and FSM stay in dmem_lsu.

## Test plan
- Reset clear: preload, hold rst=0 for 3 cycles, release. busy=1 for exactly DEPTH cycles; first req_ready=1 is at cycle DEPTH. Every word then reads 0. Assert rst=0 again at sweep index 500 → the sweep restarts and busy lasts a full DEPTH cycles again.
- Byte lanes:
  - Store word 0x11223344 @0x10.
  - Store byte 0xAA @0x11.
  - Store half 0xBEEF @0x12.
  - Load word @0x10 → 0xBEEFAA44.
- Extension:
  - Load byte signed @0x11 → 0xFFFFFFAA.
  - Load byte unsigned @0x11 → 0x000000AA.
  - Load half signed @0x12 → 0xFFFFBEEF.
- Errors, each → rsp_err=1 and rsp_rdata=0 with memory unchanged:
  - word store @0x13
  - half load @0x01
  - size=11
  - address 4*DEPTH
- Streaming: 8 back-to-back requests with req_valid held high; each response appears exactly 1 cycle after its accept. Store 0xCAFEF00D @0x20 at T, load @0x20 at T+1 → 0xCAFEF00D at T+2.
- Reset in READY with a load accepted: rst=0 on the next edge → rsp_valid=0, busy=1, and the sweep restarts.
